// File: rtl/byte_serial_pkg.sv
// rtl/byte_serial_pkg.sv - shared types and constants for the byte-serial adder
package byte_serial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-byte build still needs a one-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/csl8bit.sv
// rtl/csl8bit.sv - 8-bit carry-select adder slice
module csl8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;

    assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
    // Both upper-nibble candidates are formed up front; the low carry only selects.
    assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
    assign w_hi1 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;

    assign o_sum  = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
    assign o_cout = w_lo[4] ? w_hi1[4] : w_hi0[4];

endmodule

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - multi-byte adder summing one byte per clock through csl8bit
module byte_serial_adder
    import byte_serial_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IDX_W-1:0] r_idx;

    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic [7:0]       w_byte_sum;
    logic             w_byte_cout;
    logic             w_accept;
    logic             w_last;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);

    always_comb begin
        w_a_byte = 8'd0;
        w_b_byte = 8'd0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_byte = r_a[i*BYTE_W +: BYTE_W];
                w_b_byte = r_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    csl8bit u_csl8bit (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_sum  (w_byte_sum),
        .o_cout (w_byte_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sum   <= '0;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*BYTE_W +: BYTE_W] <= w_byte_sum;
                        end
                    end
                    r_carry <= w_byte_cout;
                    // The index parks on the last byte so it never wraps.
                    if (w_last) begin
                        r_cout <= w_byte_cout;
                        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_byte_sum[7] != r_a[W-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - scoreboard bench for byte_serial_adder (NBYTES=4 and NBYTES=1)
module tb_byte_serial_adder;

    localparam int N4 = 4;
    localparam int W4 = 32;
    localparam int N1 = 1;
    localparam int W1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic          rst4, iv4, ir4, cin4, ov4, or4, cout4, ovf4;
    logic [W4-1:0] a4, b4, sum4;
    logic          rst1, iv1, ir1, cin1, ov1, or1, cout1, ovf1;
    logic [W1-1:0] a1, b1, sum1;

    byte_serial_adder #(.NBYTES(N4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    byte_serial_adder #(.NBYTES(N1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, sum[63:0]} for a w-bit add.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
        logic [64:0] s;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b} + {64'd0, c};
        ovf = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {s[w], ovf, s[63:0] & ((64'd1 << w) - 64'd1)};
    endfunction

    logic [65:0] q4[$];
    logic [65:0] q1[$];
    int n_acc4 = 0, n_out4 = 0, acc_cyc4 = -1, n_acc1 = 0, n_out1 = 0, acc_cyc1 = -1;
    logic bb4 = 1'b0, bb1 = 1'b0, prev_ov4 = 1'b0, prev_ov1 = 1'b0;

    always @(negedge clk) begin
        logic [65:0] e;
        if (rst4) begin
            q4.delete();
        end else begin
            if (ov4 && !prev_ov4) check("latency4", 64'(cyc - acc_cyc4), 64'(N4 + 1));
            if (ov4 && or4) begin
                if (q4.size() == 0) check("spurious_out4", 64'd1, 64'd0);
                else begin
                    e = q4.pop_front();
                    check("sum4", 64'(sum4), e[63:0]);
                    check("cout4", 64'(cout4), 64'(e[65]));
                    check("ovf4", 64'(ovf4), 64'(e[64]));
                    n_out4++;
                end
            end
            if (iv4 && ir4) begin
                q4.push_back(model(W4, 64'(a4), 64'(b4), cin4));
                if (bb4 && acc_cyc4 >= 0) check("ii4", 64'(cyc - acc_cyc4), 64'(N4 + 2));
                acc_cyc4 = cyc;
                n_acc4++;
            end
        end
        prev_ov4 = ov4;
    end

    always @(negedge clk) begin
        logic [65:0] e;
        if (rst1) begin
            q1.delete();
        end else begin
            if (ov1 && !prev_ov1) check("latency1", 64'(cyc - acc_cyc1), 64'(N1 + 1));
            if (ov1 && or1) begin
                if (q1.size() == 0) check("spurious_out1", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front();
                    check("sum1", 64'(sum1), e[63:0]);
                    check("cout1", 64'(cout1), 64'(e[65]));
                    check("ovf1", 64'(ovf1), 64'(e[64]));
                    n_out1++;
                end
            end
            if (iv1 && ir1) begin
                q1.push_back(model(W1, 64'(a1), 64'(b1), cin1));
                if (bb1 && acc_cyc1 >= 0) check("ii1", 64'(cyc - acc_cyc1), 64'(N1 + 2));
                acc_cyc1 = cyc;
                n_acc1++;
            end
        end
        prev_ov1 = ov1;
    end

    task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic c);
        int n = 0;
        a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
        @(negedge clk);
        while (!ir4 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send4_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic send1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic c);
        int n = 0;
        a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
        @(negedge clk);
        while (!ir1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send1_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    task automatic drain4();
        int n = 0;
        or4 = 1'b1;
        while (q4.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("drain4_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain1();
        int n = 0;
        or1 = 1'b1;
        while (q1.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("drain1_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int saved;
        rst4 = 1'b1; iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(ir4), 64'd0);
        check("rst_out_valid", 64'(ov4), 64'd0);
        check("rst_sum", 64'(sum4), 64'd0);
        check("rst_cout_ovf", 64'({cout4, ovf4}), 64'd0);
        rst4 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(ir4), 64'd1);

        // Directed test-plan vectors, checked by the scoreboard and by held outputs.
        or4 = 1'b1;
        send4(32'h000000FF, 32'h00000001, 1'b0);
        drain4();
        check("tp_byte_carry", 64'({cout4, ovf4, sum4}), 64'({2'b00, 32'h00000100}));
        send4(32'hFFFFFFFF, 32'h00000000, 1'b1);
        drain4();
        check("tp_ripple", 64'({cout4, ovf4, sum4}), 64'({2'b10, 32'h00000000}));
        send4(32'h7FFFFFFF, 32'h00000001, 1'b0);
        drain4();
        check("tp_ovf", 64'({cout4, ovf4, sum4}), 64'({2'b01, 32'h80000000}));

        // Back-to-back random operations at minimum initiation interval.
        bb4 = 1'b1;
        acc_cyc4 = -1;
        for (int i = 0; i < 6; i++) send4($urandom, $urandom, 1'($urandom));
        drain4();
        bb4 = 1'b0;

        // Backpressure in DONE while new operands are offered.
        or4 = 1'b0;
        send4(32'h11223344, 32'h01010101, 1'b1);
        n = 0;
        while (!ov4 && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_reached_done", 64'(ov4), 64'd1);
        saved = n_acc4;
        a4 = 32'h40000000; b4 = 32'h40000000; cin4 = 1'b0; iv4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(ov4), 64'd1);
            check("bp_in_ready", 64'(ir4), 64'd0);
            check("bp_hold", 64'({cout4, ovf4, sum4}), 64'({2'b00, 32'h12233446}));
        end
        check("bp_no_accept", 64'(n_acc4), 64'(saved));
        or4 = 1'b1;
        n = 0;
        while (n_acc4 == saved && n < 50) begin @(posedge clk); #1; n++; end
        iv4 = 1'b0;
        check("bp_new_accepted", 64'(n_acc4), 64'(saved + 1));
        drain4();
        check("bp_new_result", 64'({cout4, ovf4, sum4}), 64'({2'b01, 32'h80000000}));

        // Reset while idx==2; the aborted operation must never emerge.
        send4(32'hAAAAAAAA, 32'h55555555, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        saved = n_out4;
        rst4 = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 64'(ov4), 64'd0);
        check("abort_sum", 64'(sum4), 64'd0);
        rst4 = 1'b0;
        #1;
        check("abort_in_ready", 64'(ir4), 64'd1);
        repeat (8) begin @(posedge clk); #1; end
        check("abort_no_result", 64'(n_out4), 64'(saved));
        send4(32'h12345678, 32'h11111111, 1'b0);
        drain4();
        check("after_abort", 64'(sum4), 64'h23456789);

        // Single-byte build: one-cycle RUN, II of 3.
        or1 = 1'b1;
        bb1 = 1'b1;
        acc_cyc1 = -1;
        send1(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 4; i++) send1(8'($urandom), 8'($urandom), 1'($urandom));
        drain1();
        bb1 = 1'b0;
        send1(8'h80, 8'h80, 1'b0);
        drain1();
        check("nb1_vector", 64'({cout1, ovf1, sum1}), 64'({2'b11, 8'h00}));

        check("q4_empty", 64'(q4.size()), 64'd0);
        check("q1_empty", 64'(q1.size()), 64'd0);
        check("n_out4", 64'(n_out4), 64'(n_acc4 - 1));
        check("n_out1", 64'(n_out1), 64'(n_acc1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
